// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX packet FIFO.
//   fifo_word_t : one stored beat {data, keep, last}
//   wr_state_t  : write-side frame FSM states
//   AXIS_*_W    : AXI-Stream data / keep widths
package eth_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
  } fifo_word_t;

  localparam int FIFO_WORD_W = $bits(fifo_word_t);

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_RECV = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
//   clk     : clock
//   wr_en   : write strobe, wr_addr / wr_data
//   rd_en   : read strobe, rd_addr; rd_data valid the cycle after rd_en
// No reset on the array or read register so it maps onto block RAM.
module sdp_ram #(
  parameter int WIDTH  = 73,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_tx_pkt_fifo.sv
// Store-and-forward TX packet FIFO between the frame builder and the MAC.
// A frame becomes visible to the read side only once its tlast beat has
// been committed; aborted, empty-tailed or overflowing frames are rolled
// back and counted.
//   coreclk, areset        : clock, synchronous active-high reset
//   s_axis_*               : frame input (never back-pressured outside reset)
//   m_axis_*               : frame output to MAC (tuser tied 0)
//   drop_count             : discarded frames, saturating
//   frame_count            : frames delivered to MAC, wrapping
//
// Write FSM
//   state   | meaning
//   WR_IDLE | between frames, commit_ptr == wr_ptr
//   WR_RECV | storing beats of a frame, not yet committed
//   WR_DROP | frame overflowed, discarding beats until tlast
module eth_tx_pkt_fifo
  import eth_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   coreclk,
  input  logic                   areset,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [31:0]            drop_count,
  output logic [31:0]            frame_count
);

  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t DEPTH_PTR = ptr_t'(DEPTH);

  wr_state_t state, state_next;
  ptr_t      wr_ptr, wr_ptr_next, commit_ptr, commit_next, rd_ptr;
  logic      full, empty, s_beat, ram_we, drop_inc;
  fifo_word_t wr_word, rd_word, skid0, skid1;
  logic [FIFO_WORD_W-1:0] ram_rd_data;
  logic       inflight, issue, pop;
  logic [1:0] skid_cnt;
  logic [2:0] occ;

  assign s_axis_tready = ~areset;
  assign s_beat        = s_axis_tvalid & s_axis_tready;
  assign full          = (wr_ptr - rd_ptr) == DEPTH_PTR;
  assign empty         = rd_ptr == commit_ptr;

  assign wr_word.data = s_axis_tdata;
  assign wr_word.keep = s_axis_tkeep;
  assign wr_word.last = s_axis_tlast;

  sdp_ram #(
    .WIDTH  (FIFO_WORD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (coreclk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_word),
    .rd_en   (issue),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  assign rd_word = fifo_word_t'(ram_rd_data);

  // ---------------- write side ----------------
  always_ff @(posedge coreclk) begin
    if (areset) begin
      state      <= WR_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_next;
      wr_ptr     <= wr_ptr_next;
      commit_ptr <= commit_next;
      if (drop_inc && (drop_count != 32'hFFFF_FFFF)) drop_count <= drop_count + 32'd1;
    end
  end

  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    commit_next = commit_ptr;
    ram_we      = 1'b0;
    drop_inc    = 1'b0;
    if (s_beat) begin
      unique case (state)
        WR_IDLE, WR_RECV: begin
          if (full) begin
            // Overflow: the partial frame can never be completed.
            if (s_axis_tlast) begin
              wr_ptr_next = commit_ptr;
              drop_inc    = 1'b1;
              state_next  = WR_IDLE;
            end else begin
              state_next  = WR_DROP;
            end
          end else if (s_axis_tlast) begin
            if (s_axis_tuser || (s_axis_tkeep == '0)) begin
              wr_ptr_next = commit_ptr;
              drop_inc    = 1'b1;
            end else begin
              ram_we      = 1'b1;
              wr_ptr_next = wr_ptr + ptr_t'(1);
              commit_next = wr_ptr + ptr_t'(1);
            end
            state_next = WR_IDLE;
          end else begin
            ram_we      = 1'b1;
            wr_ptr_next = wr_ptr + ptr_t'(1);
            state_next  = WR_RECV;
          end
        end
        WR_DROP: begin
          if (s_axis_tlast) begin
            wr_ptr_next = commit_ptr;
            drop_inc    = 1'b1;
            state_next  = WR_IDLE;
          end
        end
        default: state_next = WR_IDLE;
      endcase
    end
  end

  // ---------------- read side ----------------
  // Two-entry skid behind the 1-cycle RAM read. A read is issued whenever
  // the skid plus the beat in flight, less the beat leaving this cycle,
  // leaves room; this sustains one beat per cycle with tready held high.
  assign pop   = (skid_cnt != 2'd0) & m_axis_tready;
  assign occ   = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue = ~areset & ~empty & (occ < 3'd2);

  always_ff @(posedge coreclk) begin
    if (areset) begin
      rd_ptr      <= '0;
      inflight    <= 1'b0;
      skid_cnt    <= 2'd0;
      skid0       <= '0;
      skid1       <= '0;
      frame_count <= '0;
    end else begin
      rd_ptr   <= rd_ptr + ptr_t'(issue);
      inflight <= issue;
      unique case ({inflight, pop})
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= rd_word;
          end else begin
            skid0 <= skid1;
            skid1 <= rd_word;
          end
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= rd_word;
          else                  skid1 <= rd_word;
          skid_cnt <= skid_cnt + 2'd1;
        end
        default: ;
      endcase
      if (pop && skid0.last) frame_count <= frame_count + 32'd1;
    end
  end

  assign m_axis_tvalid = skid_cnt != 2'd0;
  assign m_axis_tdata  = skid0.data;
  assign m_axis_tkeep  = skid0.keep;
  assign m_axis_tlast  = skid0.last;
  assign m_axis_tuser  = 1'b0;

endmodule

// File: doc/eth_tx_pkt_fifo.md
ETH_TX_PKT_FIFO -- requirements
Module: eth_tx_pkt_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512, FIFO capacity in 64-bit beats (power of two, >=16).
REQ-002 SHALL have parameter ADDR_W, default $clog2(DEPTH), RAM address width.
REQ-003 coreclk  input  1  core clock; all logic is synchronous to its rising edge.
REQ-004 areset  input  1  reset, synchronous, active-high.
REQ-005 s_axis_tdata  input  64  frame data from frame builder, byte 0 in bits [7:0].
REQ-006 s_axis_tkeep  input  8  byte enables, contiguous from bit 0.
REQ-007 s_axis_tlast  input  1  last beat of frame.
REQ-008 s_axis_tuser  input  1  frame-abort flag, sampled on the tlast beat.
REQ-009 s_axis_tvalid  input  1  input beat valid.
REQ-010 s_axis_tready  output  1  input beat accepted.
REQ-011 m_axis_tdata  output  64  data to MAC TX (s_axis_tx_tdata).
REQ-012 m_axis_tkeep  output  8  byte enables to MAC.
REQ-013 m_axis_tlast  output  1  last beat to MAC.
REQ-014 m_axis_tuser  output  1  underrun flag to MAC; constant 0.
REQ-015 m_axis_tvalid  output  1  output beat valid.
REQ-016 m_axis_tready  input  1  MAC ready; may drop for several cycles after each tlast.
REQ-017 drop_count  output  32  frames discarded, saturating.
REQ-018 frame_count  output  32  frames fully sent to MAC, wrapping.

Function
REQ-019 SHALL be store-and-forward: no beat of a frame is presented on m_axis until its tlast beat has been committed.
REQ-020 SHALL store {tdata, tkeep, tlast} (73 bits) per beat in a simple dual-port RAM with 1-cycle registered read.
REQ-021 SHALL keep wr_ptr, commit_ptr, rd_ptr, each ADDR_W+1 bits; full = (wr_ptr - rd_ptr) == DEPTH; empty = rd_ptr == commit_ptr; wrap by natural overflow.
REQ-022 Write FSM states: IDLE, RECV, DROP; IDLE->RECV on first accepted beat without tlast; RECV->IDLE on tlast; RECV->DROP when a beat arrives while full; DROP->IDLE on tlast.
REQ-023 s_axis_tready SHALL be 1 except during reset; beats arriving while full are discarded, never back-pressured.
REQ-024 On tlast accepted with tuser=0, tkeep!=0 and no overflow in the frame: commit_ptr <= wr_ptr+1 at the same edge.
REQ-025 On tlast with tuser=1, tkeep==0, or in DROP: wr_ptr <= commit_ptr, drop_count += 1 (saturate at 0xFFFF_FFFF).
REQ-026 A single-beat frame (tlast on first beat) SHALL follow REQ-024/025 directly from IDLE.
REQ-027 Frames longer than DEPTH beats SHALL be dropped via DROP.
REQ-028 Read side SHALL use a 2-entry output skid so m_axis sustains one beat per cycle while m_axis_tready=1, including back-to-back frames.
REQ-029 Latency: tlast committed at edge E into an empty FIFO with idle output -> m_axis_tvalid=1 after edge E+2.
REQ-030 Once m_axis_tvalid is asserted it SHALL hold with stable data until m_axis_tready=1.
REQ-031 Within a committed frame m_axis_tvalid SHALL not drop between beats while m_axis_tready=1.
REQ-032 frame_count SHALL increment on each m_axis tlast handshake.
REQ-033 Simultaneous commit and read of the same slot SHALL be correct; RAM write-first conflict never occurs since reads stop at commit_ptr.

Reset
REQ-034 While areset=1: all pointers 0, FSM IDLE, skid empty, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, s_axis_tready=0, drop_count=0, frame_count=0.
REQ-035 Reset mid-frame SHALL discard all stored and partial frames without incrementing drop_count; RAM contents need not be cleared.

Structure
REQ-036 Package eth_pkg SHALL hold the fifo_word_t struct {data[63:0], keep[7:0], last}, the write FSM state enum, and AXIS width constants (64, 8).
REQ-037 RAM SHALL be a sub-module sdp_ram (parameters WIDTH, ADDR_W; registered read port), inferable as block RAM.

Verification
REQ-038 Single 8-beat frame, tkeep last=0x0F, tready=1 -> identical 8 beats out, first m_tvalid 2 edges after input tlast, frame_count=1.
REQ-039 Frame with tuser=1 on tlast, then valid 3-beat frame -> only 3-beat frame emitted, drop_count=1.
REQ-040 DEPTH=16, 20-beat frame followed by 4-beat frame -> 20-beat dropped, 4-beat emitted, drop_count=1.
REQ-041 10 back-to-back 1-beat frames, m_tready pattern 1,0,0,1 repeating -> all 10 emitted in order, no beat duplicated or lost, data stable while stalled.
REQ-042 Continuous 64-beat frames, m_tready=1 -> output 1 beat/cycle with no gap after first frame.
REQ-043 areset asserted after beat 3 of a 6-beat frame -> outputs at reset values; next 2-beat frame emitted correctly, drop_count=0.
